// File: rtl/iqdemap_psk.sv
// Hard-decision BPSK/QPSK demapper: slices I/Q samples into bits and packs them
// MSB-first into FRAME_BITS-wide words, with per-sample raw decisions alongside.
module iqdemap_psk #(
  parameter int SW         = 11,
  parameter int FRAME_BITS = 128,
  parameter int CW         = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ce,
  input  logic                  valid_i,
  input  logic signed [SW-1:0]  ar,
  input  logic signed [SW-1:0]  ai,
  input  logic                  mode,
  input  logic                  sync,
  output logic                  valid_o,
  output logic [FRAME_BITS-1:0] writer_data,
  output logic                  valid_raw,
  output logic [1:0]            raw,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         count_base;
  logic [CW-1:0]         count_sum;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_nxt;
  logic [FRAME_BITS-1:0] shreg_base;
  logic [FRAME_BITS-1:0] shreg_sum;
  logic                  mode_q;
  logic                  mode_nxt;
  logic                  mode_eff;
  logic                  accept;
  logic                  frame_done;
  logic                  d_i;
  logic                  d_q;

  assign accept = ce & valid_i;

  // Strictly positive decides 1: sign bit clear and not all-zero.
  assign d_i = ~ar[SW-1] & (|ar);
  assign d_q = ~ai[SW-1] & (|ai);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      mode_q      <= 1'b0;
      valid_o     <= 1'b0;
      writer_data <= '0;
      valid_raw   <= 1'b0;
      raw         <= 2'b00;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      shreg     <= shreg_nxt;
      mode_q    <= mode_nxt;
      valid_o   <= frame_done;
      valid_raw <= accept;
      if (frame_done) begin
        writer_data <= shreg_sum;
      end
      if (accept) begin
        raw <= {d_i, mode_eff & d_q};
      end
    end
  end

  // sync clears first, so a sample in the same cycle becomes bit 0 of a new frame.
  always_comb begin
    count_base = sync ? '0 : count;
    shreg_base = sync ? '0 : shreg;
    mode_eff   = (count_base == '0) ? mode : mode_q;
    mode_nxt   = (accept && (count_base == '0)) ? mode : mode_q;
    shreg_sum  = mode_eff ? {shreg_base[FRAME_BITS-3:0], d_i, d_q}
                          : {shreg_base[FRAME_BITS-2:0], d_i};
    count_sum  = count_base + (mode_eff ? CW'(2) : CW'(1));
    frame_done = accept && (count_sum == CW'(FRAME_BITS));
    count_nxt  = count_base;
    shreg_nxt  = shreg_base;
    if (accept) begin
      shreg_nxt = shreg_sum;
      count_nxt = frame_done ? '0 : count_sum;
    end
    state_nxt = (count_nxt == '0) ? IDLE : ACC;
  end

  always_comb begin
    busy = (state == ACC);
  end

endmodule

// File: tb/tb_iqdemap_psk.sv
// Self-checking bench for iqdemap_psk: a bit-queue reference model compared every
// cycle, directed frame scenarios with literal expectations, then random traffic.
module tb_iqdemap_psk;

  localparam int SW = 11;
  localparam int FB = 128;
  localparam int CW = 8;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic                 ce = 1'b0;
  logic                 valid_i = 1'b0;
  logic signed [SW-1:0] ar = '0;
  logic signed [SW-1:0] ai = '0;
  logic                 mode = 1'b0;
  logic                 sync = 1'b0;
  logic                 valid_o;
  logic [FB-1:0]        writer_data;
  logic                 valid_raw;
  logic [1:0]           raw;
  logic                 busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vo_count = 0;
  int vr_count = 0;
  int vo_times[$];

  bit            bits[$];
  logic          fmode = 1'b0;
  logic          exp_vo = 1'b0;
  logic [FB-1:0] exp_wd = '0;
  logic          exp_vr = 1'b0;
  logic [1:0]    exp_raw = 2'b00;
  logic          exp_busy = 1'b0;

  iqdemap_psk #(.SW(SW), .FRAME_BITS(FB), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .ar(ar), .ai(ai),
    .mode(mode), .sync(sync), .valid_o(valid_o), .writer_data(writer_data),
    .valid_raw(valid_raw), .raw(raw), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic c, input logic v, input int a_v, input int q_v,
                                input logic m, input logic s);
    ce      = c;
    valid_i = v;
    ar      = a_v[SW-1:0];
    ai      = q_v[SW-1:0];
    mode    = m;
    sync    = s;
    @(posedge CLK);
    #1;
  endtask

  function automatic int pick_sample();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0:       return 0;
      1:       return -1;
      2:       return 1;
      3:       return -1024;
      4:       return 1023;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  // Reference model: bits of the current frame held in a queue, packed MSB-first on completion.
  always @(posedge CLK) begin
    int  ari;
    int  aqi;
    bit  di;
    bit  dq;
    if (!RST) begin
      bits.delete();
      fmode    = 1'b0;
      exp_vo   = 1'b0;
      exp_wd   = '0;
      exp_vr   = 1'b0;
      exp_raw  = 2'b00;
      exp_busy = 1'b0;
    end else begin
      exp_vo = 1'b0;
      exp_vr = 1'b0;
      if (sync) bits.delete();
      if (ce && valid_i) begin
        ari = ar;
        aqi = ai;
        di  = ari > 0;
        dq  = aqi > 0;
        if (bits.size() == 0) fmode = mode;
        bits.push_back(di);
        if (fmode) bits.push_back(dq);
        exp_vr  = 1'b1;
        exp_raw = {di, fmode & dq};
        if (bits.size() == FB) begin
          for (int k = 0; k < FB; k++) exp_wd[FB-1-k] = bits[k];
          exp_vo = 1'b1;
          bits.delete();
        end
      end
      exp_busy = bits.size() != 0;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (valid_o === 1'b1) begin
      vo_count++;
      vo_times.push_back(cyc);
    end
    if (valid_raw === 1'b1) vr_count++;
    check_output("valid_o", FB'(valid_o), FB'(exp_vo));
    check_output("writer_data", writer_data, exp_wd);
    check_output("valid_raw", FB'(valid_raw), FB'(exp_vr));
    check_output("raw", FB'(raw), FB'(exp_raw));
    check_output("busy", FB'(busy), FB'(exp_busy));
  end

  initial begin
    int snap_vo;
    int snap_vr;
    int acc;
    int i;

    RST = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("rst_valid_o", FB'(valid_o), '0);
    check_output("rst_writer_data", writer_data, '0);
    check_output("rst_busy", FB'(busy), '0);
    check_output("rst_raw", FB'(raw), '0);
    RST = 1'b1;

    $display("[TB] BPSK alternating frame");
    for (int k = 0; k < FB; k++) apply_stimulus(1, 1, (k % 2 == 0) ? 100 : -100, 0, 0, 0);
    check_output("t1_valid_o", FB'(valid_o), FB'(1));
    check_output("t1_writer_data", writer_data, {16{8'hAA}});
    check_output("t1_model", exp_wd, {16{8'hAA}});
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("t1_pulse_width", FB'(valid_o), '0);

    $display("[TB] QPSK frame");
    snap_vr = vr_count;
    for (int k = 0; k < FB / 2; k++) apply_stimulus(1, 1, 5, -5, 1, 0);
    check_output("t2_writer_data", writer_data, {32{4'hA}});
    check_output("t2_raw", FB'(raw), FB'(2'b10));
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("t2_raw_pulses", FB'(vr_count - snap_vr), FB'(FB / 2));

    $display("[TB] zero and negative samples");
    for (int k = 0; k < FB; k++) apply_stimulus(1, 1, (k < FB / 2) ? 0 : -1024, 7, 0, 0);
    check_output("t3_writer_data", writer_data, '0);
    check_output("t3_raw", FB'(raw), '0);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] back-to-back BPSK frames");
    snap_vo = vo_count;
    for (int k = 0; k < 2 * FB; k++) apply_stimulus(1, 1, pick_sample(), pick_sample(), 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("t4_pulses", FB'(vo_count - snap_vo), FB'(2));
    if (vo_times.size() >= 2)
      check_output("t4_gap", FB'(vo_times[$] - vo_times[$-1]), FB'(FB));

    $display("[TB] gating and sync");
    acc = 0;
    i = 0;
    while (acc < 40) begin
      apply_stimulus((i % 2) == 0, 1, pick_sample(), pick_sample(), 0, 0);
      if ((i % 2) == 0) acc++;
      i++;
    end
    check_output("t5_busy_pre_sync", FB'(busy), FB'(1));
    apply_stimulus(0, 1, 0, 0, 0, 1);
    check_output("t5_busy_post_sync", FB'(busy), '0);
    check_output("t5_sync_no_vo", FB'(valid_o), '0);
    snap_vo = vo_count;
    acc = 0;
    i = 0;
    while (acc < FB) begin
      if (acc == FB - 1 && (i % 2) == 0)
        check_output("t5_no_early_vo", FB'(vo_count - snap_vo), '0);
      apply_stimulus((i % 2) == 0, 1, pick_sample(), pick_sample(), 0, 0);
      if ((i % 2) == 0) acc++;
      i++;
    end
    check_output("t5_vo", FB'(valid_o), FB'(1));

    $display("[TB] sync on completing edge");
    for (int k = 0; k < FB - 1; k++) apply_stimulus(1, 1, pick_sample(), 0, 0, 0);
    apply_stimulus(1, 1, 50, 0, 0, 1);
    check_output("t5b_dropped", FB'(valid_o), '0);
    check_output("t5b_busy", FB'(busy), FB'(1));
    apply_stimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] mode change and reset mid-frame");
    for (int k = 0; k < 10; k++) apply_stimulus(1, 1, pick_sample(), 0, 0, 0);
    for (int k = 0; k < 40; k++) apply_stimulus(1, 1, pick_sample(), 5, 1, 0);
    check_output("t6_still_bpsk", FB'(raw[0]), '0);
    check_output("t6_busy", FB'(busy), FB'(1));
    RST = 1'b0;
    apply_stimulus(1, 1, 5, 5, 1, 0);
    check_output("t6_rst_writer_data", writer_data, '0);
    check_output("t6_rst_valid_raw", FB'(valid_raw), '0);
    check_output("t6_rst_raw", FB'(raw), '0);
    check_output("t6_rst_busy", FB'(busy), '0);
    RST = 1'b1;

    $display("[TB] random traffic");
    for (int k = 0; k < 2500; k++) begin
      RST = ($urandom_range(0, 499) != 0);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                     pick_sample(), pick_sample(), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 63) == 0);
    end
    RST = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
